// File: rtl/ibex_pkg.sv
// Shared ibex types: opcodes, multiplier/divider ops and the custom MAC unit.
// The MAC op encodings come from funct3 of OPCODE_CUSTOM_0 instructions.
package ibex_pkg;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_CUSTOM_0 = 7'h0b,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33
    } opcode_e;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [2:0] {
        CUST_MAC  = 3'b000,
        CUST_CLR  = 3'b001,
        CUST_RDLO = 3'b010,
        CUST_RDHI = 3'b011,
        CUST_WRLO = 3'b100,
        CUST_WRHI = 3'b101
    } cust_op_e;

    typedef enum logic [1:0] {
        CUST_IDLE,
        CUST_MUL,
        CUST_DONE
    } cust_state_e;

    localparam logic [4:0] CUST_MUL_LAST = 5'd31;

    function automatic logic cust_op_legal(input logic [2:0] op);
        return op[2:1] != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_custom_mac.sv
// Custom-0 multiply-accumulate unit with a 64-bit accumulator.
// MAC uses a 32-cycle shift-add; all other ops complete in one cycle.
module ibex_custom_mac
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        illegal_o
);

    cust_state_e state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] mcand_q, sum_q;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q;
    logic        accept, legal;

    assign accept = req_i & ready_o & ~kill_i;
    assign legal  = cust_op_legal(op_q);

    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        illegal_o = 1'b0;
        result_o  = '0;
        acc_d     = acc_q;
        unique case (state_q)
            CUST_IDLE: begin
                ready_o = 1'b1;
                if (req_i && !kill_i) begin
                    state_d = (op_i == CUST_MAC) ? CUST_MUL : CUST_DONE;
                end
            end
            CUST_MUL: begin
                if (kill_i) begin
                    state_d = CUST_IDLE;
                end else if (cnt_q == CUST_MUL_LAST) begin
                    state_d = CUST_DONE;
                end
            end
            CUST_DONE: begin
                state_d   = CUST_IDLE;
                valid_o   = ~kill_i;
                illegal_o = ~kill_i & ~legal;
                if (!kill_i && legal) begin
                    case (op_q)
                        CUST_MAC: begin
                            acc_d    = sum_q;
                            result_o = sum_q[31:0];
                        end
                        CUST_CLR:  acc_d = '0;
                        CUST_RDLO: result_o = acc_q[31:0];
                        CUST_RDHI: result_o = acc_q[63:32];
                        CUST_WRLO: begin
                            acc_d[31:0] = a_q;
                            result_o    = a_q;
                        end
                        CUST_WRHI: begin
                            acc_d[63:32] = a_q;
                            result_o     = a_q;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = CUST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CUST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (accept) begin
                op_q    <= op_i;
                a_q     <= operand_a_i;
                b_q     <= operand_b_i;
                mcand_q <= {32'b0, operand_a_i};
                // Pending sum starts from acc and is committed only in DONE.
                sum_q   <= acc_q;
                cnt_q   <= '0;
            end else if (state_q == CUST_MUL) begin
                if (b_q[0]) begin
                    sum_q <= sum_q + mcand_q;
                end
                mcand_q <= mcand_q << 1;
                b_q     <= b_q >> 1;
                cnt_q   <= cnt_q + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_custom_mac.sv
// Directed bench for ibex_custom_mac: op results, latency, kill and reset.
module tb_ibex_custom_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        kill = 1'b0;
    logic        ready, valid, illegal;
    logic [31:0] result;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    ibex_custom_mac dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .op_i        (op),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .kill_i      (kill),
        .ready_o     (ready),
        .valid_o     (valid),
        .result_o    (result),
        .illegal_o   (illegal)
    );

    // Waits for an idle cycle, then presents a request for one edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++;
            $display("FAIL issue_ready: ready stayed %b, required 1", ready);
        end
        req = 1'b1;
        op  = o;
        opa = a;
        opb = b;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Counts edges after acceptance until valid; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready);
        else passed++;
        total++;
        if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid);
        else passed++;
        total++;
        if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal);
        else passed++;
        total++;
        if (result !== 32'h0) $display("FAIL rst_result: got %h want 0", result);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_mac;
        int n;
        issue(3'b001, 32'h0, 32'h0);
        total++;
        if (valid !== 1'b1 || result !== 32'h0)
            $display("FAIL clr: valid %b result %h want 1/0", valid, result);
        else passed++;
        issue(3'b000, 32'd3, 32'd5);
        opa = 32'hdead_beef;
        opb = 32'h1234_5678;
        wait_valid(n);
        total++;
        if (n !== 32) $display("FAIL mac_latency: got %0d want 32", n);
        else passed++;
        total++;
        if (result !== 32'd15 || illegal !== 1'b0)
            $display("FAIL mac_3x5: result %h illegal %b want f/0", result, illegal);
        else passed++;
        issue(3'b011, 32'h0, 32'h0);
        total++;
        if (valid !== 1'b1 || result !== 32'h0)
            $display("FAIL mac_rdhi: valid %b result %h want 1/0", valid, result);
        else passed++;
    endtask

    task automatic test_wrap;
        int n;
        issue(3'b100, 32'hffff_ffff, 32'h0);
        total++;
        if (valid !== 1'b1 || result !== 32'hffff_ffff)
            $display("FAIL wrlo: valid %b result %h want 1/ffffffff", valid, result);
        else passed++;
        issue(3'b101, 32'hffff_ffff, 32'h0);
        total++;
        if (result !== 32'hffff_ffff)
            $display("FAIL wrhi: result %h want ffffffff", result);
        else passed++;
        issue(3'b000, 32'd1, 32'd1);
        wait_valid(n);
        total++;
        if (n !== 32 || result !== 32'h0)
            $display("FAIL wrap_mac: n %0d result %h want 32/0", n, result);
        else passed++;
        issue(3'b011, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0) $display("FAIL wrap_rdhi: result %h want 0", result);
        else passed++;
    endtask

    task automatic test_kill;
        int seen;
        issue(3'b101, 32'h0, 32'h0);
        issue(3'b100, 32'h10, 32'h0);
        issue(3'b000, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        total++;
        if (ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL kill_mul: ready %b valid %b want 1/0", ready, valid);
        else passed++;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL kill_no_valid: pulses %0d want 0", seen);
        else passed++;
        issue(3'b010, 32'h0, 32'h0);
        total++;
        if (result !== 32'h10) $display("FAIL kill_rdlo: result %h want 10", result);
        else passed++;
        issue(3'b100, 32'h5, 32'h0);
        kill = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || result !== 32'h0)
            $display("FAIL kill_done: valid %b result %h want 0/0", valid, result);
        else passed++;
        @(posedge clk);
        #1;
        kill = 1'b0;
        issue(3'b010, 32'h0, 32'h0);
        total++;
        if (result !== 32'h10) $display("FAIL kill_done_acc: result %h want 10", result);
        else passed++;
        @(negedge clk);
        req  = 1'b1;
        kill = 1'b1;
        op   = 3'b001;
        @(posedge clk);
        #1;
        req  = 1'b0;
        kill = 1'b0;
        total++;
        if (ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL kill_prio: ready %b valid %b want 1/0", ready, valid);
        else passed++;
    endtask

    task automatic test_illegal;
        issue(3'b111, 32'h55, 32'h66);
        total++;
        if (valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0)
            $display("FAIL illegal: v %b i %b r %h want 1/1/0", valid, illegal, result);
        else passed++;
        issue(3'b010, 32'h0, 32'h0);
        total++;
        if (result !== 32'h10 || illegal !== 1'b0)
            $display("FAIL illegal_rdlo: result %h want 10", result);
        else passed++;
    endtask

    task automatic test_reset_mid;
        issue(3'b000, 32'd2, 32'd3);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL rst_mid: ready %b valid %b want 1/0", ready, valid);
        else passed++;
        issue(3'b010, 32'h0, 32'h0);
        total++;
        if (result !== 32'h0) $display("FAIL rst_mid_rdlo: result %h want 0", result);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] v;
        @(negedge clk);
        while (!ready) @(negedge clk);
        req = 1'b1;
        op  = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            v[i] = valid;
        end
        req = 1'b0;
        total++;
        if (v !== 4'b0101) $display("FAIL b2b_pulses: got %b want 0101", v);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mac();
        test_wrap();
        test_kill();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ibex_custom_mac.md
IBEX_CUSTOM_MAC -- requirements
Module: ibex_custom_mac

Interface
REQ-001 SHALL have clk_i  input  1  core clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-003 SHALL have req_i  input  1  ID stage requests an OPCODE_CUSTOM_0 operation.
REQ-004 SHALL have op_i  input  3  cust_op_e, taken from instruction funct3.
REQ-005 SHALL have operand_a_i  input  32  rs1 value.
REQ-006 SHALL have operand_b_i  input  32  rs2 value.
REQ-007 SHALL have kill_i  input  1  abort from the controller (flush or exception).
REQ-008 SHALL have ready_o  output  1  unit idle and able to accept a request.
REQ-009 SHALL have valid_o  output  1  single-cycle pulse marking result_o valid.
REQ-010 SHALL have result_o  output  32  rd write data.
REQ-011 SHALL have illegal_o  output  1  qualifies valid_o; op_i was unsupported.

Function
REQ-012 SHALL hold a 64-bit accumulator acc, and SHALL change it only in state DONE.
REQ-013 SHALL implement FSM states IDLE, MUL and DONE.
 - IDLE: ready_o=1. A request is accepted when req_i=1, ready_o=1 and kill_i=0.
 - On acceptance, next state is MUL for CUST_MAC and DONE for every other op.
 - MUL: 32 cycles, then DONE.
 - DONE: exactly one cycle, then IDLE.
REQ-014 SHALL register op_i and both operands on acceptance, and SHALL ignore input changes after acceptance.
REQ-015 SHALL implement these op encodings:
 - 000 CUST_MAC: acc <= acc + a*b (unsigned 32x32->64, wraps mod 2^64); result = new acc[31:0].
 - 001 CUST_CLR: acc <= 0; result 0.
 - 010 CUST_RDLO: result acc[31:0].
 - 011 CUST_RDHI: result acc[63:32].
 - 100 CUST_WRLO: acc[31:0] <= a; result a.
 - 101 CUST_WRHI: acc[63:32] <= a; result a.
 - 110 and 111: illegal.
REQ-016 SHALL compute the MUL state by iterative shift-add, one multiplier bit of b per cycle, LSB first, with a 5-bit iteration counter; the pending sum SHALL be held apart from acc until DONE.
REQ-017 SHALL meet these latencies, counting acceptance at edge T:
 - non-MAC ops: valid_o high in cycle T+1;
 - CUST_MAC: valid_o high in cycle T+33.
REQ-018 SHALL assert valid_o only in DONE while kill_i=0, and SHALL hold result_o at 0 whenever valid_o=0.
REQ-019 SHALL, for an illegal op, assert valid_o and illegal_o together, drive result_o=0, and leave acc unchanged.
REQ-020 SHALL, when kill_i=1 in MUL or DONE, go to IDLE next cycle with no valid_o and with acc unchanged.
REQ-021 SHALL give kill_i priority over req_i in IDLE, so the request is not accepted.
REQ-022 SHALL hold ready_o=0 in MUL and DONE; a req_i held through DONE is accepted no earlier than the following IDLE cycle.

Reset
REQ-023 SHALL, with rst_i=1 at a clock edge, set state to IDLE, acc to 0 and the counter to 0, and SHALL take effect from any state, including mid-MUL.
REQ-024 SHALL drive these reset output values: ready_o=1, valid_o=0, illegal_o=0, result_o=0.

Structure
REQ-025 SHALL declare cust_op_e (3-bit) and the FSM state enum in ibex_pkg, next to md_op_e; decoding uses the existing OPCODE_CUSTOM_0.
REQ-026 SHALL be a single module with no sub-modules; the shift-add datapath is inline.

Verification
REQ-027 SHALL cover: CLR, then MAC with a=3, b=5 -> valid_o at T+33 with result_o=15; RDHI -> 0.
REQ-028 SHALL cover: WRLO and WRHI with 0xFFFFFFFF, then MAC 1*1 -> result_o=0; RDHI -> 0 (wrap-around).
REQ-029 SHALL cover: acc=0x10, MAC 7*9, kill_i pulsed in MUL cycle 10 -> no valid_o; ready_o=1 next cycle; RDLO -> 0x10.
REQ-030 SHALL cover: op_i=111 -> valid_o=1, illegal_o=1 at T+1 with result_o=0; following RDLO returns the prior acc.
REQ-031 SHALL cover: rst_i asserted in MUL cycle 20 -> next cycle ready_o=1 and valid_o=0; RDLO -> 0.
REQ-032 SHALL cover: req_i held high with RDLO back-to-back -> accepted every second cycle; valid_o pulses at T+1 and T+3.
